uart_frame_decoder: RTL

//  Serial UART receiver; the downstream partner of the UART encoder.
//  - Frame: start(0), 8 data bits LSB first, even parity bit (= ^data), then 1 or 2 stop bits(1).
//  - Deframes RX into a byte held in an output register with a valid/ready handshake.
//  - Flags parity, stop (framing) and overrun errors; feeds the parallel consumer logic.

---
 rtl/uart_frame_decoder.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_decoder.sv
// -----------------------------------------------------------------------------
// uart_frame_decoder
//
// Serial UART receiver. Deframes start(0) + 8 data bits (LSB first) + even
// parity + 1 or 2 stop bits(1) from RX into a byte register presented to a
// parallel consumer with a valid/ready handshake. Parity, stop (framing) and
// overrun errors are flagged alongside the byte.
//
// Optional build macro:
//   UART_RX_SYNC_EN  - when defined, RX passes through a 2-flop synchronizer
//                      (reset value 1) before use, adding exactly 2 clk of
//                      latency. When undefined, RX is used directly and must
//                      already be synchronous to clk.
//
// Parameters:
//   CLKS_PER_BIT   clk cycles per serial bit (>=1)
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   RX             in   serial line, idle high
//   stop_1_2       in   0 = one stop bit, 1 = two stop bits (sampled at STOP1)
//   dado           out  received byte (register)
//   dado_valido    out  dado/flags valid, held until accepted
//   pronto         in   consumer ready; dado_valido & pronto = accepted
//   erro_paridade  out  parity mismatch for the byte in dado
//   erro_stop      out  a stop bit sampled 0 for the byte in dado
//   overrun        out  1-cycle pulse: completed frame dropped, buffer full
//   recebendo      out  high while the receiver is not IDLE
// -----------------------------------------------------------------------------
module uart_frame_decoder #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RX,
   input  logic       stop_1_2,
   output logic [7:0] dado,
   output logic       dado_valido,
   input  logic       pronto,
   output logic       erro_paridade,
   output logic       erro_stop,
   output logic       overrun,
   output logic       recebendo
);

   // Phase counter covers 0..CLKS_PER_BIT-1; at least one bit wide.
   localparam int PH_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [PH_W-1:0] PH_ZERO = PH_W'(0);
   localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP1     = 3'd4,
      STOP2     = 3'd5,
      WAIT_HIGH = 3'd6
   } state_t;

   // Even parity of a data byte: the value the parity bit should carry.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

   state_t          state_r;
   logic [PH_W-1:0] phase_r;
   logic [2:0]      bit_cnt_r;
   logic [7:0]      data_r;
   logic            perr_r;
   logic            s1_r;
   logic            recebendo_r;

   logic [7:0]      dado_r;
   logic            dado_valido_r;
   logic            erro_paridade_r;
   logic            erro_stop_r;
   logic            overrun_r;

   logic            rx_s;
   logic            at_mid_s;
   logic            at_end_s;
   logic            frame_done_s;
   logic            stop_ok_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0]      sync_r;

   // Two-flop synchronizer for the asynchronous serial line; idles high.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], RX};
      end
   end

   assign rx_s = sync_r[1];
`else
   assign rx_s = RX;
`endif

   assign at_mid_s = (phase_r == PH_MID);
   assign at_end_s = (phase_r == PH_LAST);

   // Frame completes on the edge sampling the last stop bit; stop_ok covers
   // every stop bit of the frame (s1 is already registered in STOP2).
   always_comb begin
      frame_done_s = 1'b0;
      stop_ok_s    = rx_s;
      if (at_mid_s && (state_r == STOP2)) begin
         frame_done_s = 1'b1;
         stop_ok_s    = s1_r & rx_s;
      end else if (at_mid_s && (state_r == STOP1) && !stop_1_2) begin
         frame_done_s = 1'b1;
         stop_ok_s    = rx_s;
      end else begin
         frame_done_s = 1'b0;
         stop_ok_s    = rx_s;
      end
   end

   // Receive state machine: bit timing, sampling and frame assembly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         phase_r     <= PH_ZERO;
         bit_cnt_r   <= 3'd0;
         data_r      <= 8'h00;
         perr_r      <= 1'b0;
         s1_r        <= 1'b1;
         recebendo_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               phase_r   <= PH_ZERO;
               bit_cnt_r <= 3'd0;
               if (!rx_s) begin
                  // This cycle is phase 0 of the start bit.
                  recebendo_r <= 1'b1;
                  if (CLKS_PER_BIT == 1) begin
                     state_r <= DATA;
                  end else begin
                     state_r <= START;
                     phase_r <= PH_ONE;
                  end
               end else begin
                  recebendo_r <= 1'b0;
               end
            end

            START: begin
               if (at_mid_s && rx_s) begin
                  // Line back high mid start bit: treat as a glitch.
                  state_r     <= IDLE;
                  phase_r     <= PH_ZERO;
                  recebendo_r <= 1'b0;
               end else if (at_end_s) begin
                  state_r <= DATA;
                  phase_r <= PH_ZERO;
               end else begin
                  phase_r <= phase_r + PH_ONE;
               end
            end

            DATA: begin
               if (at_mid_s) begin
                  data_r[bit_cnt_r] <= rx_s;
               end
               if (at_end_s) begin
                  phase_r <= PH_ZERO;
                  if (bit_cnt_r == 3'd7) begin
                     bit_cnt_r <= 3'd0;
                     state_r   <= PARITY;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                  end
               end else begin
                  phase_r <= phase_r + PH_ONE;
               end
            end

            PARITY: begin
               if (at_mid_s) begin
                  perr_r <= rx_s ^ even_parity(data_r);
               end
               if (at_end_s) begin
                  state_r <= STOP1;
                  phase_r <= PH_ZERO;
               end else begin
                  phase_r <= phase_r + PH_ONE;
               end
            end

            STOP1: begin
               if (at_mid_s) begin
                  s1_r <= rx_s;
                  if (stop_1_2) begin
                     if (at_end_s) begin
                        state_r <= STOP2;
                        phase_r <= PH_ZERO;
                     end else begin
                        phase_r <= phase_r + PH_ONE;
                     end
                  end else begin
                     // Single stop bit: frame ends here, rest of bit ignored.
                     phase_r <= PH_ZERO;
                     if (rx_s) begin
                        state_r     <= IDLE;
                        recebendo_r <= 1'b0;
                     end else begin
                        state_r <= WAIT_HIGH;
                     end
                  end
               end else if (at_end_s) begin
                  // Only reachable in two-stop mode; one-stop leaves at MID.
                  state_r <= STOP2;
                  phase_r <= PH_ZERO;
               end else begin
                  phase_r <= phase_r + PH_ONE;
               end
            end

            STOP2: begin
               if (at_mid_s) begin
                  phase_r <= PH_ZERO;
                  if (s1_r && rx_s) begin
                     state_r     <= IDLE;
                     recebendo_r <= 1'b0;
                  end else begin
                     state_r <= WAIT_HIGH;
                  end
               end else begin
                  phase_r <= phase_r + PH_ONE;
               end
            end

            WAIT_HIGH: begin
               // Break: a low line is never taken as a new start bit.
               phase_r <= PH_ZERO;
               if (rx_s) begin
                  state_r     <= IDLE;
                  recebendo_r <= 1'b0;
               end else begin
                  recebendo_r <= 1'b1;
               end
            end

            default: begin
               state_r     <= IDLE;
               phase_r     <= PH_ZERO;
               bit_cnt_r   <= 3'd0;
               recebendo_r <= 1'b0;
            end
         endcase
      end
   end

   // Single-entry output buffer with valid/ready handshake and overrun pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         dado_r          <= 8'h00;
         dado_valido_r   <= 1'b0;
         erro_paridade_r <= 1'b0;
         erro_stop_r     <= 1'b0;
         overrun_r       <= 1'b0;
      end else begin
         overrun_r <= 1'b0;
         if (dado_valido_r && pronto) begin
            dado_valido_r <= 1'b0;
         end
         if (frame_done_s) begin
            // A byte accepted this same cycle frees the slot for the new one.
            if (!dado_valido_r || pronto) begin
               dado_r          <= data_r;
               erro_paridade_r <= perr_r;
               erro_stop_r     <= ~stop_ok_s;
               dado_valido_r   <= 1'b1;
            end else begin
               overrun_r <= 1'b1;
            end
         end
      end
   end

   assign dado          = dado_r;
   assign dado_valido   = dado_valido_r;
   assign erro_paridade = erro_paridade_r;
   assign erro_stop     = erro_stop_r;
   assign overrun       = overrun_r;
   assign recebendo     = recebendo_r;

endmodule
